// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: word/byte loads and stores through a direct-mapped
// write-through, no-write-allocate data cache backed by a req/ack memory port.
module mem_stage #(
    parameter int LINES = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             is_LB_SB,
    input  logic             cache_en,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      rt_data,
    output logic [31:0]      load_data,
    output logic             freeze,
    output logic             dm_req,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic [3:0]       dm_wstrb,
    input  logic             dm_ack,
    input  logic [31:0]      dm_rdata,
    output logic [CNT_W-1:0] ld_hits,
    output logic [CNT_W-1:0] ld_misses
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t          state;
    logic [31:0]     data_q [LINES];
    logic [TW-1:0]   tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [31:0]     buf_q;

    logic [IW-1:0]   index;
    logic [TW-1:0]   tag;
    logic [1:0]      lane;
    logic            is_store;
    logic            is_load;
    logic            hit;
    logic [3:0]      wstrb_c;
    logic [31:0]     wdata_c;
    logic [31:0]     merged;

    assign index    = alu_result[IW+1:2];
    assign tag      = alu_result[31:IW+2];
    assign lane     = alu_result[1:0];
    assign is_store = mem_write;
    assign is_load  = mem_to_reg & ~mem_write;
    assign hit      = cache_en & valid_q[index] & (tag_q[index] == tag);
    assign dm_addr  = {alu_result[31:2], 2'b00};

    assign wstrb_c  = is_LB_SB ? (4'b0001 << lane) : 4'hF;
    assign wdata_c  = is_LB_SB ? {4{rt_data[7:0]}} : rt_data;

    always_comb begin
        merged = data_q[index];
        for (int i = 0; i < 4; i++) begin
            if (wstrb_c[i]) merged[8*i +: 8] = wdata_c[8*i +: 8];
        end
    end

    // LB picks the addressed little-endian byte and sign-extends; LW passes the word through.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic lb, input logic [1:0] ln);
        logic [31:0] sh;
        sh = w >> {ln, 3'b000};
        return lb ? {{24{sh[7]}}, sh[7:0]} : w;
    endfunction

    always_comb begin
        freeze    = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_wstrb  = 4'h0;
        dm_wdata  = 32'h0;
        load_data = 32'h0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    freeze = 1'b1;
                end else if (is_load) begin
                    if (hit) load_data = fmt(data_q[index], is_LB_SB, lane);
                    else     freeze    = 1'b1;
                end
            end
            FILL: begin
                dm_req = 1'b1;
                freeze = 1'b1;
            end
            WRITE: begin
                dm_req   = 1'b1;
                dm_we    = 1'b1;
                freeze   = 1'b1;
                dm_wstrb = wstrb_c;
                dm_wdata = wdata_c;
            end
            DONE: load_data = buf_q;
            default: ;
        endcase
        if (!rst_b) begin
            freeze = 1'b0;
            dm_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            valid_q   <= '0;
            buf_q     <= 32'h0;
            ld_hits   <= '0;
            ld_misses <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_store) begin
                        state <= WRITE;
                    end else if (is_load) begin
                        if (hit) begin
                            if (ld_hits != '1) ld_hits <= ld_hits + 1'b1;
                        end else begin
                            state <= FILL;
                            if (cache_en && ld_misses != '1) ld_misses <= ld_misses + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (dm_ack) begin
                        buf_q <= fmt(dm_rdata, is_LB_SB, lane);
                        state <= DONE;
                        if (cache_en) valid_q[index] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (dm_ack) begin
                        buf_q <= 32'h0;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (state == FILL && dm_ack && cache_en) begin
            data_q[index] <= dm_rdata;
            tag_q[index]  <= tag;
        end else if (state == WRITE && dm_ack && hit) begin
            data_q[index] <= merged;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a delayed-ack memory model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        mem_write = 1'b0, mem_to_reg = 1'b0, is_LB_SB = 1'b0, cache_en = 1'b0;
    logic [31:0] alu_result = 32'h0, rt_data = 32'h0;
    logic [31:0] load_data, dm_addr, dm_wdata, dm_rdata;
    logic        freeze, dm_req, dm_we, dm_ack;
    logic [3:0]  dm_wstrb;
    logic [15:0] ld_hits, ld_misses;

    mem_stage #(.LINES(64), .CNT_W(16)) dut (
        .clk(clk), .rst_b(rst_b), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .is_LB_SB(is_LB_SB), .cache_en(cache_en), .alu_result(alu_result), .rt_data(rt_data),
        .load_data(load_data), .freeze(freeze), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .ld_hits(ld_hits), .ld_misses(ld_misses)
    );

    always #5 clk = ~clk;

    int          ack_delay = 1;
    int          ack_cnt;
    logic [31:0] rd_word = 32'h0;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata, cap_addr;

    assign dm_ack   = dm_req && (ack_cnt == ack_delay - 1);
    assign dm_rdata = rd_word;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b)               ack_cnt <= 0;
        else if (!dm_req || dm_ack) ack_cnt <= 0;
        else                      ack_cnt <= ack_cnt + 1;
    end

    always @(posedge clk) begin
        if (dm_req && dm_ack && dm_we) begin
            cap_wstrb <= dm_wstrb;
            cap_wdata <= dm_wdata;
            cap_addr  <= dm_addr;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] data;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    // Retirement = an access is presented and freeze is low; stalls are counted per access.
    int mon_stalls = 0;
    always @(negedge clk) begin
        if (rst_b && (mem_write || mem_to_reg)) begin
            if (freeze) begin
                mon_stalls++;
            end else if (sb.size() == 0) begin
                check("unexpected_retire", 32'h1, 32'h0);
                mon_stalls = 0;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_data"}, load_data, e.data);
                check({e.nm, "_stalls"}, mon_stalls, e.stalls);
                mon_stalls = 0;
            end
        end else begin
            mon_stalls = 0;
        end
    end

    task automatic access(input string nm, input bit wr, input bit rd, input bit lb, input bit ce,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp,
                          input int stalls);
        int n;
        exp_t e;
        e.nm = nm; e.data = exp; e.stalls = stalls;
        sb.push_back(e);
        @(posedge clk); #1;
        mem_write = wr; mem_to_reg = rd; is_LB_SB = lb; cache_en = ce;
        alu_result = a; rt_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (freeze && n < 50);
        if (n >= 50) check({nm, "_timeout"}, 32'h1, 32'h0);
        @(posedge clk); #1;
        mem_write = 1'b0; mem_to_reg = 1'b0; is_LB_SB = 1'b0; cache_en = 1'b0;
        alu_result = 32'h0; rt_data = 32'h0;
    endtask

    initial begin
        #12;
        check("rst_load_data", load_data, 32'h0);
        check("rst_freeze", {31'h0, freeze}, 32'h0);
        check("rst_dm_req", {31'h0, dm_req}, 32'h0);
        check("rst_dm_we", {31'h0, dm_we}, 32'h0);
        check("rst_wstrb", {28'h0, dm_wstrb}, 32'h0);
        check("rst_hits", {16'h0, ld_hits}, 32'h0);
        @(negedge clk); rst_b = 1'b1;

        ack_delay = 3; rd_word = 32'hDEADBEEF;
        access("t1_lw_cold", 0, 1, 0, 1, 32'h100, 0, 32'hDEADBEEF, 4);
        check("t1_misses", {16'h0, ld_misses}, 32'd1);
        check("t1_hits", {16'h0, ld_hits}, 32'd0);
        rd_word = 32'h0;
        access("t2_lw_hit", 0, 1, 0, 1, 32'h100, 0, 32'hDEADBEEF, 0);
        check("t2_hits", {16'h0, ld_hits}, 32'd1);

        ack_delay = 1;
        access("t3_sb", 1, 0, 1, 1, 32'h102, 32'h000000AA, 32'h0, 2);
        check("t3_wstrb", {28'h0, cap_wstrb}, 32'h4);
        check("t3_wdata", cap_wdata, 32'hAAAAAAAA);
        check("t3_addr", cap_addr, 32'h100);
        access("t3_lw_merged", 0, 1, 0, 1, 32'h100, 0, 32'hDEAABEEF, 0);

        access("t4_lb3", 0, 1, 1, 1, 32'h103, 0, 32'hFFFFFFDE, 0);
        access("t4_lb0", 0, 1, 1, 1, 32'h100, 0, 32'hFFFFFFEF, 0);

        ack_delay = 2; rd_word = 32'h12345678;
        access("t5_lw_uncached", 0, 1, 0, 0, 32'h100, 0, 32'h12345678, 3);
        ack_delay = 1;
        access("t5_lw_still_hit", 0, 1, 0, 1, 32'h100, 0, 32'hDEAABEEF, 0);
        check("t5_hits", {16'h0, ld_hits}, 32'd5);
        check("t5_misses", {16'h0, ld_misses}, 32'd1);

        access("sw_uncached", 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 2);
        access("lw_after_unc_sw", 0, 1, 0, 1, 32'h100, 0, 32'hDEAABEEF, 0);
        access("both_set_store", 1, 1, 0, 1, 32'h100, 32'hCAFEF00D, 32'h0, 2);
        access("lw_after_sw_hit", 0, 1, 0, 1, 32'h100, 0, 32'hCAFEF00D, 0);

        access("sw_miss_noalloc", 1, 0, 0, 1, 32'h200, 32'h11223344, 32'h0, 2);
        check("sw_wstrb", {28'h0, cap_wstrb}, 32'hF);
        check("sw_wdata", cap_wdata, 32'h11223344);
        rd_word = 32'h55667788;
        access("lw_200_miss", 0, 1, 0, 1, 32'h200, 0, 32'h55667788, 2);
        access("lb_202_pos", 0, 1, 1, 1, 32'h202, 0, 32'h00000066, 0);
        rd_word = 32'h0BADF00D;
        access("lw_100_evicted", 0, 1, 0, 1, 32'h100, 0, 32'h0BADF00D, 2);
        check("pre_rst_hits", {16'h0, ld_hits}, 32'd8);
        check("pre_rst_misses", {16'h0, ld_misses}, 32'd3);

        ack_delay = 10;
        @(posedge clk); #1;
        mem_to_reg = 1'b1; cache_en = 1'b1; alu_result = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        check("t6_in_fill_req", {31'h0, dm_req}, 32'h1);
        rst_b = 1'b0;
        #1;
        check("t6_rst_dm_req", {31'h0, dm_req}, 32'h0);
        check("t6_rst_freeze", {31'h0, freeze}, 32'h0);
        check("t6_rst_misses", {16'h0, ld_misses}, 32'h0);
        mem_to_reg = 1'b0; cache_en = 1'b0; alu_result = 32'h0;
        @(posedge clk); #1 rst_b = 1'b1;

        ack_delay = 1; rd_word = 32'h55667788;
        access("t6_lw_200_remiss", 0, 1, 0, 1, 32'h200, 0, 32'h55667788, 2);
        check("t6_misses", {16'h0, ld_misses}, 32'd1);

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
